mdio_master: RTL and testbench
==============================

Name: mdio_master

Overview:
- Clause 22 MDIO management master that configures the board's GMII PHY (speed, autonegotiation, LEDs) after the top-level PHY reset is released.
- Sits beside fpga_core in the 125 MHz core clock domain.
- Takes read/write commands over a valid/ready interface, serialises them into MDC/MDIO frames, and returns the read data.

Parameters:
- CLK_DIV, 25, core-clock cycles per MDC half-period. Legal range 1..255. 125 MHz / 50 gives 2.5 MHz MDC.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  master can accept a command
- cmd_read  input  1  1 = read (OP 10), 0 = write (OP 01)
- cmd_phy_addr  input  5  PHYAD
- cmd_reg_addr  input  5  REGAD
- cmd_data  input  16  write data; ignored for reads
- rd_data  output  16  last read result
- rd_data_valid  output  1  one-cycle strobe when rd_data updates
- busy  output  1  frame in progress
- mdc  output  1  management clock
- mdio_i  input  1  MDIO pad input
- mdio_o  output  1  MDIO pad output
- mdio_t  output  1  tristate control: 1 = release the pad (high-Z)

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: cmd_ready=0 while rst is high, then 1. rd_data=0, rd_data_valid=0, busy=0, mdc=0, mdio_o=1, mdio_t=1.
- States:
  - IDLE: cmd_ready=1.
  - SHIFT: frame in progress, busy=1, cmd_ready=0.
  - DONE: single cycle.
- IDLE -> SHIFT: on cmd_valid & cmd_ready, latch all cmd_* fields. A command held while busy is not accepted until the next IDLE.
- Frame: 64 bits, MSB first.
  - 32 preamble ones.
  - ST = 01.
  - OP = 01 (write) or 10 (read).
  - PHYAD[4:0], then REGAD[4:0].
  - TA: write drives 10; read releases the pad (mdio_t=1) for both TA bits.
  - DATA[15:0]: write drives cmd_data; read releases the pad and samples.
- Bit timing: each bit lasts 2*CLK_DIV cycles.
  - mdc is low for the first CLK_DIV cycles of a bit and high for the second.
  - mdio_o/mdio_t change only in the cycle mdc goes low, i.e. at the start of each bit. Bit 0 is presented the cycle after acceptance.
  - mdio_i is sampled in the cycle mdc goes high.
- Counters: an 8-bit prescale counter and a 6-bit bit counter. The frame ends after the bit counter reaches 63 and that bit's high phase completes. Total 128*CLK_DIV cycles from the accept cycle to DONE.
- DONE:
  - Next edge: mdc=0, mdio_t=1, mdio_o=1.
  - For reads, rd_data gets the 16 sampled bits and rd_data_valid=1 for exactly one cycle. Writes leave rd_data unchanged.
  - Return to IDLE; cmd_ready=1 the following cycle.
  - Minimum spacing of back-to-back frames: 128*CLK_DIV+2 cycles.
- The TA-bit sample on reads is ignored; there is no error reporting.
- Reset mid-frame: the next edge forces all reset values and IDLE, no rd_data_valid pulse, and the partial frame is dropped.
- cmd_valid in the same cycle as rst: ignored.

Test Plan:
- Write with CLK_DIV=2: PHYAD=0x07, REGAD=0x00, data 0x1140 -> mdc period 4 cycles; mdio_o sequence is 32x'1', 01 01 00111 00000 10 0001000101000000; mdio_t=0 throughout; busy high for 256 cycles; no rd_data_valid.
- Read with CLK_DIV=2: PHYAD=0x07, REGAD=0x02; PHY model drives 0x0141 on mdio_i at falling edges during DATA -> mdio_t=1 from the first TA bit; rd_data=0x0141; rd_data_valid pulses once; cmd_ready returns the cycle after the pulse.
- Back-to-back: cmd_valid held high with two queued commands -> second accepted exactly 258 cycles after the first (CLK_DIV=2); cmd_ready=0 throughout frame one.
- Reset mid-frame: assert rst during bit 40 of a read -> next cycle mdc=0, mdio_t=1, mdio_o=1, busy=0; no rd_data_valid; rd_data stays 0; a new write after reset is framed correctly.
- CLK_DIV=1 boundary: read with mdio_i tied high -> mdc toggles every cycle; frame is 128 cycles; rd_data=0xFFFF.
- Default CLK_DIV=25: any write -> mdc high/low phases exactly 25 cycles each; frame is 3200 cycles.

Source files
------------

// File: rtl/mdio_master.sv
`timescale 1ns/1ps
// Clause 22 MDIO management master: accepts read/write commands over valid/ready
// and serialises them into 64-bit MDC/MDIO frames, returning read data.
module mdio_master #(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_data,
  output logic [15:0] rd_data,
  output logic        rd_data_valid,
  output logic        busy,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] PRESC_MAX = 8'(CLK_DIV - 1);

  state_t       state;
  state_t       state_nxt;
  logic [7:0]   presc;
  logic [5:0]   bit_cnt;
  logic [62:0]  next_bits;
  logic         is_read;
  logic [15:0]  rd_shift;
  logic [15:0]  rd_nxt;
  logic         accept;
  logic         phase_end;
  logic         bit_end;
  logic         frame_end;
  logic         sample_now;
  logic [62:0]  frame_tail;

  assign accept     = cmd_valid && cmd_ready;
  assign phase_end  = (state == SHIFT) && (presc == PRESC_MAX);
  assign bit_end    = phase_end && mdc;
  assign frame_end  = bit_end && (bit_cnt == 6'd63);
  // Read data is taken during the first cycle of each DATA bit's high phase.
  assign sample_now = (state == SHIFT) && mdc && (presc == 8'd0) && is_read &&
                      (bit_cnt >= 6'd48);
  assign rd_nxt     = sample_now ? {rd_shift[14:0], mdio_i} : rd_shift;

  // Bits 1..63 of the frame; bit 0 is a preamble one driven directly at accept.
  // Released read bits (TA, DATA) are filled with ones so the idle pad level is kept.
  assign frame_tail = {31'h7FFF_FFFF, 2'b01,
                       (cmd_read ? 2'b10 : 2'b01),
                       cmd_phy_addr, cmd_reg_addr,
                       (cmd_read ? 2'b11 : 2'b10),
                       (cmd_read ? 16'hFFFF : cmd_data)};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (frame_end) state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    busy      = (state == SHIFT);
  end

  // Pad/clock control and the read result: all return to idle levels on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc         <= 8'd0;
      bit_cnt       <= 6'd0;
      mdc           <= 1'b0;
      mdio_o        <= 1'b1;
      mdio_t        <= 1'b1;
      rd_data       <= 16'd0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            presc   <= 8'd0;
            bit_cnt <= 6'd0;
            mdc     <= 1'b0;
            mdio_o  <= 1'b1;
            mdio_t  <= 1'b0;
          end
        end
        SHIFT: begin
          if (phase_end) begin
            presc <= 8'd0;
            if (!mdc) begin
              mdc <= 1'b1;
            end else if (bit_cnt == 6'd63) begin
              mdc    <= 1'b0;
              mdio_o <= 1'b1;
              mdio_t <= 1'b1;
              if (is_read) begin
                rd_data       <= rd_nxt;
                rd_data_valid <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              mdc     <= 1'b0;
              mdio_o  <= next_bits[62];
              // Reads release the pad from the first TA bit (index 46) onward.
              mdio_t  <= is_read && (bit_cnt >= 6'd45);
            end
          end else begin
            presc <= presc + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame shift register and read capture carry data only.
  always_ff @(posedge clk) begin
    if (accept) begin
      next_bits <= frame_tail;
      is_read   <= cmd_read;
      rd_shift  <= 16'd0;
    end else if (state == SHIFT) begin
      rd_shift <= rd_nxt;
      if (bit_end && (bit_cnt != 6'd63))
        next_bits <= {next_bits[61:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
`timescale 1ns/1ps
// Directed bench for mdio_master at CLK_DIV = 2, 1 and 25 with a small PHY read model.
module tb_mdio_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  cmd_valid;
  logic        cmd_read;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_data;
  logic [2:0]  cmd_ready, rd_data_valid, busy, mdc, mdio_o, mdio_t;
  logic [15:0] rd_data0, rd_data1, rd_data2;
  logic        phy_mdio;
  logic [15:0] phy_data;
  int          fe_cnt;
  int          checks = 0;
  int          failures = 0;

  mdio_master #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_read(cmd_read), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_data(cmd_data), .rd_data(rd_data0), .rd_data_valid(rd_data_valid[0]),
    .busy(busy[0]), .mdc(mdc[0]), .mdio_i(phy_mdio), .mdio_o(mdio_o[0]), .mdio_t(mdio_t[0])
  );

  mdio_master #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_read(cmd_read), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_data(cmd_data), .rd_data(rd_data1), .rd_data_valid(rd_data_valid[1]),
    .busy(busy[1]), .mdc(mdc[1]), .mdio_i(1'b1), .mdio_o(mdio_o[1]), .mdio_t(mdio_t[1])
  );

  mdio_master u_div25 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_read(cmd_read), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_data(cmd_data), .rd_data(rd_data2), .rd_data_valid(rd_data_valid[2]),
    .busy(busy[2]), .mdc(mdc[2]), .mdio_i(1'b1), .mdio_o(mdio_o[2]), .mdio_t(mdio_t[2])
  );

  // PHY model: falling edge k of mdc opens bit k; DATA bits 48..63 carry phy_data MSB first.
  always @(negedge mdc[0]) begin
    if (busy[0] && fe_cnt < 63) begin
      fe_cnt = fe_cnt + 1;
      if (fe_cnt >= 48) phy_mdio = phy_data[15 - (fe_cnt - 48)];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int sel);
    case (sel)
      0: return 2;
      1: return 1;
      default: return 25;
    endcase
  endfunction

  task automatic wait_ready(input int sel, input string tag, input int limit);
    int w;
    w = 0;
    while (cmd_ready[sel] !== 1'b1 && w < limit) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_ready"}, 64'(cmd_ready[sel]), 64'd1);
  endtask

  // Issues one command and checks the whole frame cycle by cycle, returning the
  // per-bit mdio_o / mdio_t values (bit 0 of the frame at position 63).
  task automatic run_frame(input int sel, input logic rd, input string tag,
                           output logic [63:0] fo, output logic [63:0] ft);
    int d, n_tot, bit_i, ph;
    int err_mdc, err_busy, err_rdv, err_stable;
    logic cur_o, cur_t;
    d = div_of(sel);
    n_tot = 128 * d;
    fo = '0; ft = '0;
    err_mdc = 0; err_busy = 0; err_rdv = 0; err_stable = 0;
    cur_o = 1'b1; cur_t = 1'b1;
    wait_ready(sel, tag, 20);
    fe_cnt = 0;
    phy_mdio = 1'b1;
    cmd_valid[sel] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[sel] = 1'b0;
    for (int n = 1; n <= n_tot; n++) begin
      ph = (n - 1) % (2 * d);
      if (mdc[sel] !== (ph >= d)) err_mdc++;
      if (busy[sel] !== 1'b1 || cmd_ready[sel] !== 1'b0) err_busy++;
      if (rd_data_valid[sel] !== 1'b0) err_rdv++;
      if (ph == 0) begin
        bit_i = (n - 1) / (2 * d);
        cur_o = mdio_o[sel];
        cur_t = mdio_t[sel];
        fo[63 - bit_i] = cur_o;
        ft[63 - bit_i] = cur_t;
      end else if (mdio_o[sel] !== cur_o || mdio_t[sel] !== cur_t) begin
        err_stable++;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_mdc_phase_errs"}, 64'(err_mdc), 64'd0);
    chk({tag, "_busy_errs"}, 64'(err_busy), 64'd0);
    chk({tag, "_early_rdv_errs"}, 64'(err_rdv), 64'd0);
    chk({tag, "_mdio_stable_errs"}, 64'(err_stable), 64'd0);
    chk({tag, "_done_state"},
        64'({busy[sel], cmd_ready[sel], mdc[sel], mdio_t[sel], mdio_o[sel], rd_data_valid[sel]}),
        64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rd}));
    @(posedge clk); #1;
    chk({tag, "_back_idle"}, 64'({cmd_ready[sel], rd_data_valid[sel]}), 64'b10);
  endtask

  logic [63:0] fo, ft;
  int k;

  initial begin
    rst = 1'b1;
    cmd_valid = 3'b111;
    cmd_read = 1'b0;
    cmd_phy_addr = 5'h00;
    cmd_reg_addr = 5'h00;
    cmd_data = 16'h0000;
    phy_mdio = 1'b1;
    phy_data = 16'h0000;
    fe_cnt = 0;

    // Reset state, with commands offered during reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_busy_mdc", 64'({busy, mdc}), 64'd0);
    chk("rst_mdio", 64'({mdio_o, mdio_t}), 64'b111_111);
    chk("rst_rd", 64'({rd_data_valid, rd_data0, rd_data1, rd_data2}), 64'd0);
    cmd_valid = 3'b000;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'({cmd_ready, busy}), 64'b111_000);

    // Write, CLK_DIV=2
    cmd_read = 1'b0; cmd_phy_addr = 5'h07; cmd_reg_addr = 5'h00; cmd_data = 16'h1140;
    run_frame(0, 1'b0, "wr2", fo, ft);
    chk("wr2_frame", fo, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h07, 5'h00, 2'b10, 16'h1140});
    chk("wr2_tristate", ft, 64'd0);
    chk("wr2_rd_data_kept", 64'(rd_data0), 64'd0);

    // Read, CLK_DIV=2, PHY returns 0x0141
    cmd_read = 1'b1; cmd_phy_addr = 5'h07; cmd_reg_addr = 5'h02; phy_data = 16'h0141;
    run_frame(0, 1'b1, "rd2", fo, ft);
    chk("rd2_header", 64'(fo[63:18]), 64'({32'hFFFF_FFFF, 2'b01, 2'b10, 5'h07, 5'h02}));
    chk("rd2_tristate", ft, 64'h0000_0000_0003_FFFF);
    chk("rd2_data", 64'(rd_data0), 64'h0141);

    // Back-to-back writes with cmd_valid held
    cmd_read = 1'b0; cmd_data = 16'hA5A5;
    wait_ready(0, "b2b", 20);
    cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    k = 1;
    while (cmd_ready[0] !== 1'b1 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_second_accept_cycle", 64'(k), 64'd258);
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    chk("b2b_second_busy", 64'({busy[0], cmd_ready[0]}), 64'b10);
    wait_ready(0, "b2b_end", 600);

    // Reset during bit 40 of a read
    cmd_read = 1'b1; cmd_reg_addr = 5'h02; phy_data = 16'hBEEF;
    fe_cnt = 0;
    cmd_valid[0] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    repeat (160) @(posedge clk);
    #1;
    chk("mid_before_rst_busy", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_pads", 64'({mdc[0], mdio_t[0], mdio_o[0], busy[0], rd_data_valid[0], cmd_ready[0]}),
        64'b011000);
    chk("mid_rst_rd_data", 64'(rd_data0), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_after_rst", 64'({rd_data_valid[0], cmd_ready[0], rd_data0}), 64'({2'b01, 16'h0000}));
    cmd_read = 1'b0; cmd_phy_addr = 5'h03; cmd_reg_addr = 5'h1F; cmd_data = 16'h8001;
    run_frame(0, 1'b0, "wr_after_rst", fo, ft);
    chk("wr_after_rst_frame", fo, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h03, 5'h1F, 2'b10, 16'h8001});

    // CLK_DIV=1 read with mdio_i tied high
    cmd_read = 1'b1; cmd_phy_addr = 5'h11; cmd_reg_addr = 5'h05;
    run_frame(1, 1'b1, "rd1", fo, ft);
    chk("rd1_header", 64'(fo[63:18]), 64'({32'hFFFF_FFFF, 2'b01, 2'b10, 5'h11, 5'h05}));
    chk("rd1_tristate", ft, 64'h0000_0000_0003_FFFF);
    chk("rd1_data", 64'(rd_data1), 64'hFFFF);

    // Default CLK_DIV=25 write
    cmd_read = 1'b0; cmd_phy_addr = 5'h01; cmd_reg_addr = 5'h04; cmd_data = 16'h01E1;
    run_frame(2, 1'b0, "wr25", fo, ft);
    chk("wr25_frame", fo, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h04, 2'b10, 16'h01E1});
    chk("wr25_rd_data_kept", 64'(rd_data2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
